// File: rtl/pipeline_pkg.sv
// Shared types and sizing for the pipeline MEM stage.
package pipeline_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 4;
  localparam int TIMEOUT    = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_stage_mem_wb.sv
// MEM/WB pipeline register; a stall turns the captured slot into a bubble.
module MEM_WB_FF
  import pipeline_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_stall,
  input  logic [DATA_W-1:0]     i_wb_data,
  input  logic [REG_ADDR_W-1:0] i_dst_addr,
  input  logic                  i_we_rf,
  input  logic                  i_hlt,
  output logic [DATA_W-1:0]     o_wb_data,
  output logic [REG_ADDR_W-1:0] o_dst_addr,
  output logic                  o_we_rf,
  output logic                  o_hlt
);

  logic [DATA_W-1:0]     r_wb_data;
  logic [REG_ADDR_W-1:0] r_dst_addr;
  logic                  r_we_rf;
  logic                  r_hlt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_data  <= '0;
      r_dst_addr <= '0;
      r_we_rf    <= 1'b0;
      r_hlt      <= 1'b0;
    end else if (i_stall) begin
      // data/address held so the WB bus stays quiet during a bubble
      r_we_rf <= 1'b0;
      r_hlt   <= 1'b0;
    end else begin
      r_wb_data  <= i_wb_data;
      r_dst_addr <= i_dst_addr;
      r_we_rf    <= i_we_rf;
      r_hlt      <= i_hlt;
    end
  end

  assign o_wb_data  = r_wb_data;
  assign o_dst_addr = r_dst_addr;
  assign o_we_rf    = r_we_rf;
  assign o_hlt      = r_hlt;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory handshake FSM with timeout, stall/flush
// generation and the MEM/WB register.
module mem_stage #(
  parameter int TIMEOUT = pipeline_pkg::TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] alu_result_MEM,
  input  logic [15:0] sdata_MEM,
  input  logic [15:0] pc_MEM,
  input  logic        we_mem_MEM,
  input  logic        re_mem_MEM,
  input  logic        wb_sel_MEM,
  input  logic        we_rf_MEM,
  input  logic        b_ctrl_MEM,
  input  logic        j_ctrl_MEM,
  input  logic        hlt_MEM,
  input  logic [3:0]  dst_addr_MEM,
  output logic        dm_req,
  output logic        dm_we,
  output logic [15:0] dm_addr,
  output logic [15:0] dm_wdata,
  input  logic [15:0] dm_rdata,
  input  logic        dm_rdy,
  output logic        stall,
  output logic        flush,
  output logic [15:0] redirect_pc,
  output logic [15:0] wb_data_WB,
  output logic [3:0]  dst_addr_WB,
  output logic        we_rf_WB,
  output logic        hlt_WB,
  output logic        mem_err
);
  import pipeline_pkg::*;

  localparam logic [3:0] TO_CNT = 4'(TIMEOUT);

  mem_state_e  r_state;
  logic [3:0]  r_wait_cnt;
  logic        w_mem_op;
  logic        w_in_err;
  logic        w_stall;
  logic [15:0] w_wb_data;

  assign w_mem_op = we_mem_MEM | re_mem_MEM;
  assign w_in_err = (r_state == ERR);

  // rst_n gating drops the request and stall while reset is held low
  assign dm_req   = rst_n & w_mem_op & ~w_in_err;
  assign w_stall  = rst_n & (w_in_err | (w_mem_op & ~dm_rdy));
  assign stall    = w_stall;
  assign dm_we    = we_mem_MEM;
  assign dm_addr  = alu_result_MEM;
  assign dm_wdata = sdata_MEM;
  assign mem_err  = w_in_err;

  assign flush       = (b_ctrl_MEM | j_ctrl_MEM) & ~w_stall;
  assign redirect_pc = pc_MEM;

  // a write wins over a simultaneous read, so its write-back is the ALU value
  assign w_wb_data = (wb_sel_MEM & ~we_mem_MEM) ? dm_rdata : alu_result_MEM;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wait_cnt <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_mem_op && !dm_rdy) begin
            r_state    <= WAIT;
            r_wait_cnt <= 4'd0;
          end
        end
        WAIT: begin
          if (dm_rdy) begin
            r_state <= IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
            if (r_wait_cnt + 4'd1 == TO_CNT) r_state <= ERR;
          end
        end
        ERR:     r_state <= ERR;
        default: r_state <= IDLE;
      endcase
    end
  end

  MEM_WB_FF u_mem_wb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_stall    (w_stall),
    .i_wb_data  (w_wb_data),
    .i_dst_addr (dst_addr_MEM),
    .i_we_rf    (we_rf_MEM),
    .i_hlt      (hlt_MEM),
    .o_wb_data  (wb_data_WB),
    .o_dst_addr (dst_addr_WB),
    .o_we_rf    (we_rf_WB),
    .o_hlt      (hlt_WB)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads, stores, timeout and reset.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] alu_result_MEM, sdata_MEM, pc_MEM;
  logic        we_mem_MEM, re_mem_MEM, wb_sel_MEM, we_rf_MEM;
  logic        b_ctrl_MEM, j_ctrl_MEM, hlt_MEM;
  logic [3:0]  dst_addr_MEM;
  logic        dm_req, dm_we;
  logic [15:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_rdy;
  logic        stall, flush;
  logic [15:0] redirect_pc, wb_data_WB;
  logic [3:0]  dst_addr_WB;
  logic        we_rf_WB, hlt_WB, mem_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_result_MEM(alu_result_MEM), .sdata_MEM(sdata_MEM), .pc_MEM(pc_MEM),
    .we_mem_MEM(we_mem_MEM), .re_mem_MEM(re_mem_MEM), .wb_sel_MEM(wb_sel_MEM),
    .we_rf_MEM(we_rf_MEM), .b_ctrl_MEM(b_ctrl_MEM), .j_ctrl_MEM(j_ctrl_MEM),
    .hlt_MEM(hlt_MEM), .dst_addr_MEM(dst_addr_MEM),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_rdy(dm_rdy),
    .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
    .wb_data_WB(wb_data_WB), .dst_addr_WB(dst_addr_WB),
    .we_rf_WB(we_rf_WB), .hlt_WB(hlt_WB), .mem_err(mem_err)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    alu_result_MEM = 16'h0000; sdata_MEM = 16'h0000; pc_MEM = 16'h0000;
    we_mem_MEM = 0; re_mem_MEM = 0; wb_sel_MEM = 0; we_rf_MEM = 0;
    b_ctrl_MEM = 0; j_ctrl_MEM = 0; hlt_MEM = 0; dst_addr_MEM = 4'h0;
    dm_rdy = 0; dm_rdata = 16'h0000;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_wb_data"}, wb_data_WB, 16'h0000);
    check({tag, "_dst"}, {12'h0, dst_addr_WB}, 16'h0000);
    check({tag, "_we_rf"}, {15'h0, we_rf_WB}, 16'h0000);
    check({tag, "_hlt"}, {15'h0, hlt_WB}, 16'h0000);
    check({tag, "_mem_err"}, {15'h0, mem_err}, 16'h0000);
    check({tag, "_stall"}, {15'h0, stall}, 16'h0000);
    check({tag, "_dm_req"}, {15'h0, dm_req}, 16'h0000);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_values("rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ALU op passes through in one cycle
    alu_result_MEM = 16'h1234; we_rf_MEM = 1; dst_addr_MEM = 4'h3;
    @(negedge clk);
    check("alu_stall", {15'h0, stall}, 16'h0000);
    check("alu_req", {15'h0, dm_req}, 16'h0000);
    next_edge();
    check("alu_wb_data", wb_data_WB, 16'h1234);
    check("alu_dst", {12'h0, dst_addr_WB}, 16'h0003);
    check("alu_we_rf", {15'h0, we_rf_WB}, 16'h0001);

    // halt lasts exactly one WB cycle
    idle_inputs(); hlt_MEM = 1; alu_result_MEM = 16'h0007;
    next_edge();
    check("hlt_set", {15'h0, hlt_WB}, 16'h0001);
    check("hlt_wb_data", wb_data_WB, 16'h0007);
    idle_inputs();
    next_edge();
    check("hlt_clr", {15'h0, hlt_WB}, 16'h0000);

    // load with 3 stall cycles and a pending jump
    alu_result_MEM = 16'h0020; re_mem_MEM = 1; wb_sel_MEM = 1; we_rf_MEM = 1;
    dst_addr_MEM = 4'h5; j_ctrl_MEM = 1; pc_MEM = 16'h0100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ld_stall", {15'h0, stall}, 16'h0001);
      check("ld_req", {15'h0, dm_req}, 16'h0001);
      check("ld_flush_hold", {15'h0, flush}, 16'h0000);
      next_edge();
      check("ld_bubble_we", {15'h0, we_rf_WB}, 16'h0000);
      check("ld_bubble_data", wb_data_WB, 16'h0000);
    end
    dm_rdy = 1; dm_rdata = 16'hBEEF;
    @(negedge clk);
    check("ld_rdy_stall", {15'h0, stall}, 16'h0000);
    check("ld_flush", {15'h0, flush}, 16'h0001);
    check("ld_redirect", redirect_pc, 16'h0100);
    next_edge();
    check("ld_wb_data", wb_data_WB, 16'hBEEF);
    check("ld_we_rf", {15'h0, we_rf_WB}, 16'h0001);
    check("ld_dst", {12'h0, dst_addr_WB}, 16'h0005);
    idle_inputs();
    @(negedge clk);
    check("ld_flush_done", {15'h0, flush}, 16'h0000);

    // zero-wait store
    next_edge();
    we_mem_MEM = 1; alu_result_MEM = 16'h0040; sdata_MEM = 16'h00AA; dm_rdy = 1;
    @(negedge clk);
    check("st_req", {15'h0, dm_req}, 16'h0001);
    check("st_we", {15'h0, dm_we}, 16'h0001);
    check("st_addr", dm_addr, 16'h0040);
    check("st_wdata", dm_wdata, 16'h00AA);
    check("st_stall", {15'h0, stall}, 16'h0000);
    next_edge();
    check("st_we_rf", {15'h0, we_rf_WB}, 16'h0000);
    idle_inputs();
    @(negedge clk);
    check("st_req_off", {15'h0, dm_req}, 16'h0000);

    // write and read together: write wins, WB takes the ALU value
    next_edge();
    we_mem_MEM = 1; re_mem_MEM = 1; wb_sel_MEM = 1; we_rf_MEM = 1; dst_addr_MEM = 4'h9;
    alu_result_MEM = 16'h5555; dm_rdata = 16'hDEAD; dm_rdy = 1;
    @(negedge clk);
    check("rw_dm_we", {15'h0, dm_we}, 16'h0001);
    next_edge();
    check("rw_wb_data", wb_data_WB, 16'h5555);
    check("rw_dst", {12'h0, dst_addr_WB}, 16'h0009);
    idle_inputs();

    // dm_rdy on the timeout cycle wins over entering ERR
    next_edge();
    re_mem_MEM = 1; wb_sel_MEM = 1; we_rf_MEM = 1; dst_addr_MEM = 4'h2; alu_result_MEM = 16'h0030;
    repeat (15) next_edge();
    check("to_edge_err", {15'h0, mem_err}, 16'h0000);
    check("to_edge_stall", {15'h0, stall}, 16'h0001);
    dm_rdy = 1; dm_rdata = 16'h1111;
    next_edge();
    check("to_edge_err_after", {15'h0, mem_err}, 16'h0000);
    check("to_edge_wb_data", wb_data_WB, 16'h1111);
    check("to_edge_we_rf", {15'h0, we_rf_WB}, 16'h0001);
    idle_inputs();
    @(negedge clk);
    check("to_edge_idle", {15'h0, stall}, 16'h0000);

    // full timeout into sticky ERR, then reset
    next_edge();
    re_mem_MEM = 1; wb_sel_MEM = 1; we_rf_MEM = 1; dst_addr_MEM = 4'h4;
    repeat (15) next_edge();
    check("err_not_yet", {15'h0, mem_err}, 16'h0000);
    next_edge();
    check("err_set", {15'h0, mem_err}, 16'h0001);
    @(negedge clk);
    check("err_stall", {15'h0, stall}, 16'h0001);
    check("err_req", {15'h0, dm_req}, 16'h0000);
    dm_rdy = 1; dm_rdata = 16'h2222;
    next_edge();
    check("err_sticky", {15'h0, mem_err}, 16'h0001);
    check("err_we_rf", {15'h0, we_rf_WB}, 16'h0000);
    idle_inputs();
    @(negedge clk);
    check("err_stall_stuck", {15'h0, stall}, 16'h0001);
    re_mem_MEM = 1;
    rst_n = 1'b0;
    #1 check_reset_values("err_rst");
    idle_inputs();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // reset during the 2nd WAIT cycle, then a late dm_rdy
    re_mem_MEM = 1; wb_sel_MEM = 1; we_rf_MEM = 1; dst_addr_MEM = 4'h6; alu_result_MEM = 16'h0050;
    next_edge();
    next_edge();
    rst_n = 1'b0;
    #1;
    check("mr_req", {15'h0, dm_req}, 16'h0000);
    check("mr_stall", {15'h0, stall}, 16'h0000);
    dm_rdy = 1; dm_rdata = 16'hCAFE;
    next_edge();
    check("mr_we_rf", {15'h0, we_rf_WB}, 16'h0000);
    check("mr_wb_data", wb_data_WB, 16'h0000);
    idle_inputs();
    next_edge();
    rst_n = 1'b1;
    alu_result_MEM = 16'h00A5; we_rf_MEM = 1; dst_addr_MEM = 4'h7;
    @(negedge clk);
    check("mr_post_stall", {15'h0, stall}, 16'h0000);
    next_edge();
    check("mr_post_wb_data", wb_data_WB, 16'h00A5);
    check("mr_post_we_rf", {15'h0, we_rf_WB}, 16'h0001);
    check("mr_post_err", {15'h0, mem_err}, 16'h0000);
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, the number of WAIT cycles without dm_rdy before ERR is entered.
REQ-002 clk  input  1  the single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  asynchronous active-low reset; a low level resets all state immediately.
REQ-004 alu_result_MEM, sdata_MEM, pc_MEM  input  16 each  ALU result / memory address, store data, branch or jump target from the EX/MEM register.
REQ-005 we_mem_MEM, re_mem_MEM, wb_sel_MEM, we_rf_MEM, b_ctrl_MEM, j_ctrl_MEM, hlt_MEM  input  1 each  EX/MEM control bits; wb_sel_MEM=1 selects load data.
REQ-006 dst_addr_MEM  input  4  destination register address.
REQ-007 dm_req, dm_we  output  1 each  data-memory request and write-enable.
REQ-008 dm_addr, dm_wdata  output  16 each  data-memory address and write data.
REQ-009 dm_rdata  input  16  memory read data, valid in the cycle dm_rdy=1.
REQ-010 dm_rdy  input  1  memory completion; single-cycle pulse per request.
REQ-011 stall  output  1  freezes EX/MEM and all upstream stages.
REQ-012 flush, redirect_pc  output  1, 16  taken control transfer and its target.
REQ-013 wb_data_WB  output  16  write-back data; dst_addr_WB  output  4  write-back register address.
REQ-014 we_rf_WB, hlt_WB, mem_err  output  1 each  register-file write enable, halt, sticky timeout error.

Function
REQ-015 mem_op SHALL equal we_mem_MEM | re_mem_MEM.
REQ-016 The FSM SHALL have three states: IDLE, WAIT, ERR.
REQ-017 dm_req SHALL equal mem_op in IDLE and WAIT and SHALL be 0 in ERR.
REQ-018 dm_addr SHALL equal alu_result_MEM, dm_wdata SHALL equal sdata_MEM, and dm_we SHALL equal we_mem_MEM, all combinationally.
REQ-019 When we_mem_MEM and re_mem_MEM are both 1, the access SHALL be a write, and write-back SHALL use alu_result_MEM.
REQ-020 stall SHALL equal (mem_op & ~dm_rdy) in IDLE and WAIT, and SHALL equal 1 in ERR.
REQ-021 IDLE->WAIT SHALL occur on mem_op & ~dm_rdy; WAIT->IDLE SHALL occur on dm_rdy.
REQ-022 A zero-wait access (dm_rdy in the same cycle as the request) SHALL complete with no stall.
REQ-023 wait_cnt (4 bits) SHALL clear on entry to WAIT and increment each WAIT cycle without dm_rdy; when it reaches TIMEOUT the FSM SHALL go to ERR.
REQ-024 ERR SHALL be sticky until reset, with mem_err=1; dm_rdy in the same cycle as the timeout SHALL take priority and return the FSM to IDLE.
REQ-025 MEM/WB capture SHALL occur on each clock edge where stall=0: wb_data_WB = wb_sel_MEM ? dm_rdata : alu_result_MEM, with dst_addr_WB, we_rf_WB and hlt_WB copied from the MEM inputs.
REQ-026 When stall=1, MEM/WB SHALL capture a bubble: we_rf_WB=0 and hlt_WB=0, with data and address held.
REQ-027 Latency: a non-memory instruction SHALL reach WB one cycle after presentation; a load with N wait cycles SHALL reach WB N+1 cycles after presentation.
REQ-028 flush SHALL equal (b_ctrl_MEM | j_ctrl_MEM) & ~stall, and redirect_pc SHALL equal pc_MEM.
REQ-029 hlt_MEM with stall=0 SHALL set hlt_WB for exactly one cycle.

Reset
REQ-030 While rst_n=0: state=IDLE, wait_cnt=0, mem_err=0, wb_data_WB=16'h0000, dst_addr_WB=4'h0, we_rf_WB=0, hlt_WB=0.
REQ-031 Reset asserted mid-WAIT SHALL drop dm_req and stall in the same cycle; a dm_rdy arriving after reset SHALL be ignored.

Structure
REQ-032 Package pipeline_pkg SHALL hold the FSM state enum, TIMEOUT, DATA_W=16 and REG_ADDR_W=4.
REQ-033 The MEM/WB register SHALL be a sub-module named MEM_WB_FF, instantiated once, with stall-driven bubble insertion.

Verification
REQ-034 ALU op: alu_result_MEM=16'h1234, wb_sel=0, we_rf=1, dst=4'h3 -> next cycle wb_data_WB=16'h1234, dst_addr_WB=3, we_rf_WB=1; stall never high.
REQ-035 Load with 3 wait cycles, dm_rdata=16'hBEEF -> stall high for 3 cycles, we_rf_WB=0 during those cycles, then wb_data_WB=16'hBEEF.
REQ-036 Zero-wait store to addr 16'h0040, data 16'h00AA -> dm_req=1 and dm_we=1 for one cycle, stall=0, we_rf_WB=0.
REQ-037 No dm_rdy for 15 cycles -> ERR, mem_err=1, stall stuck at 1, dm_req=0; rst_n low -> all reset values restored.
REQ-038 j_ctrl_MEM=1 with pc_MEM=16'h0100 during a load wait -> flush=0 until dm_rdy, then flush=1 and redirect_pc=16'h0100 for one cycle.
REQ-039 Reset asserted in the 2nd WAIT cycle, then dm_rdy -> dm_req=0 immediately, state IDLE, and no WB write.
